// File: rtl/aoi211_bist_pkg.sv
// Shared types, constants and golden model for the AOI211 BIST stage.
// Vectors are packed {A1,A2,B,C} with A1 as the MSB.
package aoi211_bist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam int VEC_W   = 4;
  localparam int NUM_VEC = 16;

  function automatic logic aoi211_ref(
    input logic [VEC_W-1:0] vec
  );
    return !((vec[3] & vec[2]) | vec[1] | vec[0]);
  endfunction

endpackage

// File: rtl/aoi211_bist_sat_cnt.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones once full.
module aoi211_bist_sat_cnt #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/aoi211_bist.sv
// Exhaustive BIST around one AOI211 cell: registered sweep,
// golden compare, saturating error count and first-fail capture.
module aoi211_bist
  import aoi211_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int PASSES        = 1,
  parameter int ERR_W         = 5
) (
`ifdef USE_POWER_PINS
  inout  wire              VDD,
  inout  wire              VSS,
`endif
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  output logic             A1,
  output logic             A2,
  output logic             B,
  output logic             C,
  input  logic             ZN,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic [3:0]       FIRST_FAIL
);

  localparam int SW =
    (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int PW =
    (PASSES > 1) ? $clog2(PASSES) : 1;

  localparam logic [SW-1:0] SET_LAST = SW'(SETTLE_CYCLES);
  localparam logic [PW-1:0] PAS_LAST = PW'(PASSES - 1);

  state_t           state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [VEC_W-1:0] stim_q, stim_d;
  logic [SW-1:0]    set_q, set_d;
  logic [PW-1:0]    pas_q, pas_d;
  logic             ff_q, ff_d;
  logic [3:0]       first_q, first_d;
  logic             mism;
  logic             clr;
  logic             inc;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      vec_q   <= '0;
      stim_q  <= '0;
      set_q   <= '0;
      pas_q   <= '0;
      ff_q    <= 1'b0;
      first_q <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      stim_q  <= stim_d;
      set_q   <= set_d;
      pas_q   <= pas_d;
      ff_q    <= ff_d;
      first_q <= first_d;
    end
  end

  // X/Z on ZN must count as a failure, hence the case inequality.
  assign mism = (ZN !== aoi211_ref(vec_q));

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    set_d   = set_q;
    pas_d   = pas_q;
    ff_d    = ff_q;
    first_d = first_q;
    clr     = 1'b0;
    inc     = 1'b0;
    unique case (state_q)
      IDLE, FIN: begin
        if (START) begin
          state_d = RUN;
          vec_d   = '0;
          set_d   = '0;
          pas_d   = '0;
          ff_d    = 1'b0;
          first_d = '0;
          clr     = 1'b1;
        end
      end
      RUN: begin
        if (set_q == SET_LAST) begin
          set_d = '0;
          vec_d = vec_q + 1'b1;
          if (mism) begin
            inc = 1'b1;
            if (!ff_q) begin
              ff_d    = 1'b1;
              first_d = vec_q;
            end
          end
          if (vec_q == {VEC_W{1'b1}}) begin
            if (pas_q == PAS_LAST) begin
              state_d = FIN;
              vec_d   = '0;
              pas_d   = '0;
            end else begin
              pas_d = pas_q + 1'b1;
            end
          end
        end else begin
          set_d = set_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign stim_d = (state_d == RUN) ? vec_d : '0;

  aoi211_bist_sat_cnt #(
    .W (ERR_W)
  ) u_err (
    .clk (CLK),
    .rst (RST),
    .clr (clr),
    .inc (inc),
    .cnt (ERR_CNT)
  );

  assign {A1, A2, B, C} = stim_q;
  assign BUSY       = (state_q == RUN);
  assign DONE       = (state_q == FIN);
  assign PASS       = DONE && (ERR_CNT == '0);
  assign FIRST_FAIL = first_q;

endmodule

// File: tb/tb_aoi211_bist.sv
// Randomized self-checking bench for aoi211_bist with a
// run-level reference model and several cell fault models.
module tb_aoi211_bist;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0;
  logic       ZN;
  logic       A1, A2, B, C;
  logic       BUSY, DONE, PASS;
  logic [4:0] ERR_CNT;
  logic [3:0] FIRST_FAIL;

  logic       START2 = 1'b0;
  logic       ZN2;
  logic       A1_2, A2_2, B_2, C_2;
  logic       BUSY2, DONE2, PASS2;
  logic [3:0] ERR2;
  logic [3:0] FF2;

  int checks = 0;
  int errors = 0;

  int          mode = 0;
  int          dly = 0;
  logic [15:0] mask = '0;
  int          mode2 = 2;
  logic [15:0] mask2 = '0;

  logic       gold, gold2;
  logic [2:0] dl = '0;

  always #5 CLK = ~CLK;

  aoi211_bist dut (
    .CLK(CLK), .RST(RST), .START(START),
    .A1(A1), .A2(A2), .B(B), .C(C), .ZN(ZN),
    .BUSY(BUSY), .DONE(DONE), .PASS(PASS),
    .ERR_CNT(ERR_CNT), .FIRST_FAIL(FIRST_FAIL)
  );

  aoi211_bist #(
    .SETTLE_CYCLES(0), .PASSES(2), .ERR_W(4)
  ) dut2 (
    .CLK(CLK), .RST(RST), .START(START2),
    .A1(A1_2), .A2(A2_2), .B(B_2), .C(C_2), .ZN(ZN2),
    .BUSY(BUSY2), .DONE(DONE2), .PASS(PASS2),
    .ERR_CNT(ERR2), .FIRST_FAIL(FF2)
  );

  // Cell under test and its fault models
  assign gold  = ~((A1 & A2) | B | C);
  assign gold2 = ~((A1_2 & A2_2) | B_2 | C_2);

  always @(posedge CLK) dl <= {dl[1:0], gold};

  always_comb begin
    ZN = gold;
    case (mode)
      0: ZN = (dly == 0) ? gold : dl[dly-1];
      1: ZN = 1'b0;
      2: ZN = 1'b1;
      3: ZN = gold ^ mask[{A1, A2, B, C}];
      default: ZN = gold;
    endcase
  end

  always_comb begin
    ZN2 = 1'b1;
    if (mode2 == 3) ZN2 = gold2 ^ mask2[{A1_2, A2_2, B_2, C_2}];
  end

  // Truth table view: output is 1 only with B=C=0 and not A1&A2
  function automatic bit gold_f(input int v);
    logic [3:0] x;
    x = v[3:0];
    return (x[1:0] == 2'b00) && (x[3:2] != 2'b11);
  endfunction

  // ZN the BIST sees at sample n, given the wire history
  function automatic bit obs_f(input int n, input int s,
                               input int m, input int d,
                               input logic [15:0] mk);
    int t, sv;
    case (m)
      0: begin
        t  = (n + 1) * (s + 1) - 1 - d;
        sv = (t < 0) ? 0 : (t / (s + 1)) % 16;
        return gold_f(sv);
      end
      1: return 1'b0;
      2: return 1'b1;
      default: return gold_f(n % 16) ^ mk[n % 16];
    endcase
  endfunction

  task automatic run1(input int mid_start, input int rst_at,
                      output int fin_err, output int fin_ff);
    bit   mis [48];
    int   ee, ef, ns;
    bit   have;
    logic [15:0] got, exp;
    for (int n = 0; n < 48; n++)
      mis[n] = obs_f(n, 2, mode, dly, mask) != gold_f(n % 16);
    START = 1'b0;
    repeat (4) @(posedge CLK);
    #1 START = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
    fin_err = -1;
    fin_ff = -1;
    for (int t = 0; t <= 48; t++) begin
      if (t > 0) begin
        @(posedge CLK);
        #1;
      end
      ns = t / 3;
      ee = 0; ef = 0; have = 0;
      for (int n = 0; n < ns; n++) begin
        if (mis[n]) begin
          if (ee < 31) ee++;
          if (!have) begin
            have = 1;
            ef = n % 16;
          end
        end
      end
      exp = {(t < 48), (t >= 48), (t >= 48) && (ee == 0),
             (t < 48) ? 4'((t / 3) % 16) : 4'h0,
             5'(ee), 4'(ef)};
      got = {BUSY, DONE, PASS, A1, A2, B, C, ERR_CNT, FIRST_FAIL};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL run_cycle t=%0d mode=%0d dly=%0d got=%h exp=%h",
                 t, mode, dly, got, exp);
      end
      if (t == rst_at) begin
        RST = 1'b1;
        #1;
        got = {BUSY, DONE, PASS, A1, A2, B, C, ERR_CNT, FIRST_FAIL};
        checks++;
        if (got !== 16'h0) begin
          errors++;
          $display("FAIL async_reset got=%h exp=0000", got);
        end
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        return;
      end
      START = (t == mid_start);
    end
    fin_err = ee;
    fin_ff = ef;
  endtask

  task automatic test_reset;
    logic [15:0] got;
    RST = 1'b1;
    #1;
    got = {BUSY, DONE, PASS, A1, A2, B, C, ERR_CNT, FIRST_FAIL};
    checks++;
    if (got !== 16'h0) begin
      errors++;
      $display("FAIL reset_state got=%h exp=0000", got);
    end
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    got = {BUSY, DONE, PASS, A1, A2, B, C, ERR_CNT, FIRST_FAIL};
    checks++;
    if (got !== 16'h0) begin
      errors++;
      $display("FAIL idle_after_reset got=%h exp=0000", got);
    end
  endtask

  task automatic test_good;
    int e, f;
    mode = 0; dly = 0;
    run1(-1, -1, e, f);
    checks++;
    if ({PASS, ERR_CNT, FIRST_FAIL} !== {1'b1, 5'd0, 4'h0}) begin
      errors++;
      $display("FAIL good_cell pass=%b err=%0d ff=%h exp 1/0/0",
               PASS, ERR_CNT, FIRST_FAIL);
    end
  endtask

  task automatic test_stuck0;
    int e, f;
    mode = 1;
    run1(-1, -1, e, f);
    checks++;
    if ({PASS, ERR_CNT, FIRST_FAIL} !== {1'b0, 5'd3, 4'h0}) begin
      errors++;
      $display("FAIL stuck0 pass=%b err=%0d ff=%h exp 0/3/0",
               PASS, ERR_CNT, FIRST_FAIL);
    end
  endtask

  task automatic test_fin_restart;
    int e, f;
    checks++;
    if (DONE !== 1'b1) begin
      errors++;
      $display("FAIL fin_hold done=%b exp=1", DONE);
    end
    mode = 0; dly = 0;
    run1(-1, -1, e, f);
  endtask

  task automatic test_delay;
    int e, f;
    mode = 0; dly = 2;
    run1(-1, -1, e, f);
    checks++;
    if (PASS !== 1'b1) begin
      errors++;
      $display("FAIL delay2_settle2 pass=%b exp=1", PASS);
    end
    dly = 3;
    run1(-1, -1, e, f);
    checks++;
    if ({ERR_CNT, FIRST_FAIL} !== {5'd5, 4'h1}) begin
      errors++;
      $display("FAIL delay3_settle2 err=%0d ff=%h exp 5/1",
               ERR_CNT, FIRST_FAIL);
    end
    dly = 0;
  endtask

  task automatic test_random;
    int e, f;
    mode = 3;
    for (int i = 0; i < 4; i++) begin
      mask = 16'($urandom);
      run1(-1, -1, e, f);
    end
    mode = 0;
  endtask

  task automatic test_mid_start;
    int e, f;
    mode = 0;
    run1(10, -1, e, f);
    run1(31, -1, e, f);
  endtask

  task automatic test_reset_midrun;
    int e, f;
    mode = 1;
    run1(-1, 20, e, f);
    mode = 0;
    run1(-1, -1, e, f);
    checks++;
    if (PASS !== 1'b1) begin
      errors++;
      $display("FAIL rerun_after_reset pass=%b exp=1", PASS);
    end
  endtask

  task automatic test_saturation;
    int   ee, ef;
    bit   have;
    logic [11:0] got, exp;
    for (int r = 0; r < 3; r++) begin
      mode2 = (r == 0) ? 2 : 3;
      mask2 = 16'($urandom);
      repeat (2) @(posedge CLK);
      #1 START2 = 1'b1;
      @(posedge CLK);
      #1 START2 = 1'b0;
      for (int t = 0; t <= 32; t++) begin
        if (t > 0) begin
          @(posedge CLK);
          #1;
        end
        ee = 0; ef = 0; have = 0;
        for (int n = 0; n < t && n < 32; n++) begin
          if (obs_f(n, 0, mode2, 0, mask2) != gold_f(n % 16)) begin
            if (ee < 15) ee++;
            if (!have) begin
              have = 1;
              ef = n % 16;
            end
          end
        end
        exp = {(t < 32), (t >= 32), (t >= 32) && (ee == 0),
               (t < 32) ? 4'(t % 16) : 4'h0, 4'(ee)};
        got = {BUSY2, DONE2, PASS2, A1_2, A2_2, B_2, C_2, ERR2};
        checks++;
        if (got !== exp || FF2 !== 4'(ef)) begin
          errors++;
          $display("FAIL sat_cycle r=%0d t=%0d got=%h exp=%h ff=%h exp_ff=%h",
                   r, t, got, exp, FF2, 4'(ef));
        end
      end
      if (r == 0) begin
        checks++;
        if ({PASS2, ERR2, FF2} !== {1'b0, 4'd15, 4'h1}) begin
          errors++;
          $display("FAIL stuck1_sat pass=%b err=%0d ff=%h exp 0/15/1",
                   PASS2, ERR2, FF2);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_good();
    test_stuck0();
    test_fin_restart();
    test_delay();
    test_random();
    test_mid_start();
    test_reset_midrun();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
